// File: rtl/aes_byte_stream_mux.sv
// Handshaked N-channel byte-stream mux that locks one channel per burst, with a registered output stage.
// Define AES_BYTE_MUX_RR_EN to honour the mode input and build the round-robin arbiter.
module aes_byte_stream_mux #(
  parameter  int WIDTH     = 8,
  parameter  int NUM_CH    = 2,
  parameter  int BURST_LEN = 16,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        grant,
  output logic                    busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t            state_reg;
  logic [SEL_W-1:0]  grant_reg;
  logic              busy_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic [CNT_W-1:0]  beat_cnt_reg;

  logic [WIDTH-1:0]  ch_data [NUM_CH];
  logic [NUM_CH-1:0] ch_sel_hit;
  logic              out_slot_free;
  logic              accept;
  logic              last_beat;
  logic [WIDTH-1:0]  beat;
  logic              fix_req;
  logic              arb_req;
  logic [SEL_W-1:0]  arb_idx;

  // The output slot can take a new beat when empty or draining this cycle.
  assign out_slot_free = !out_valid_reg || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_data[gi]    = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]   = (state_reg == ST_LOCKED) && (grant_reg == SEL_W'(gi)) && out_slot_free;
      assign ch_sel_hit[gi] = in_valid[gi] && (sel == SEL_W'(gi));
    end
  endgenerate

  assign accept    = |(in_ready & in_valid);
  assign beat      = ch_data[grant_reg];
  assign last_beat = (beat_cnt_reg == CNT_W'(BURST_LEN - 1));
  // An out-of-range sel matches no channel, so the mux stays idle.
  assign fix_req   = |ch_sel_hit;

`ifdef AES_BYTE_MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_reg;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_req;
  int               rr_c;

  // Scan from the farthest offset down so the nearest valid channel after rr_ptr wins.
  always_comb begin
    rr_req = 1'b0;
    rr_idx = '0;
    rr_c   = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      rr_c = (int'(rr_ptr_reg) + k) % NUM_CH;
      if (in_valid[rr_c]) begin
        rr_req = 1'b1;
        rr_idx = SEL_W'(rr_c);
      end
    end
  end

  assign arb_req = mode ? rr_req : fix_req;
  assign arb_idx = mode ? rr_idx : sel;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign arb_req     = fix_req;
  assign arb_idx     = sel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      busy_reg      <= 1'b0;
      beat_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
`ifdef AES_BYTE_MUX_RR_EN
      rr_ptr_reg    <= SEL_W'(NUM_CH - 1);
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_req) begin
            state_reg    <= ST_LOCKED;
            grant_reg    <= arb_idx;
            busy_reg     <= 1'b1;
            beat_cnt_reg <= '0;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            if (last_beat) begin
              state_reg    <= ST_IDLE;
              busy_reg     <= 1'b0;
              beat_cnt_reg <= '0;
`ifdef AES_BYTE_MUX_RR_EN
              rr_ptr_reg   <= grant_reg;
`endif
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (accept) begin
        out_data_reg  <= beat;
        out_valid_reg <= 1'b1;
        out_last_reg  <= last_beat;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign grant     = grant_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_aes_byte_stream_mux.sv
// Directed bench for aes_byte_stream_mux: fixed-mode bursts, backpressure, mid-burst events,
// out-of-range sel, and (with AES_BYTE_MUX_RR_EN) round-robin grant order.
module tb_aes_byte_stream_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: NUM_CH=2, BURST_LEN=16
  logic        a_rst_n, a_sel, a_mode, a_out_valid, a_out_last, a_out_ready, a_grant, a_busy;
  logic [1:0]  a_in_valid, a_in_ready;
  logic [15:0] a_in_data;
  logic [7:0]  a_out_data;

  aes_byte_stream_mux #(.WIDTH(8), .NUM_CH(2), .BURST_LEN(16)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .sel(a_sel), .mode(a_mode),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_ready(a_out_ready), .grant(a_grant), .busy(a_busy)
  );

  // DUT B: NUM_CH=3 so that sel=3 is an out-of-range value
  logic        rst_n, b_mode, b_out_valid, b_out_last, b_out_ready, b_busy;
  logic [1:0]  b_sel, b_grant;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [23:0] b_in_data;
  logic [7:0]  b_out_data;

  aes_byte_stream_mux #(.WIDTH(8), .NUM_CH(3), .BURST_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel(b_sel), .mode(b_mode),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(b_out_ready), .grant(b_grant), .busy(b_busy)
  );

`ifdef AES_BYTE_MUX_RR_EN
  // DUT C: NUM_CH=4 round-robin, short bursts
  logic        c_mode, c_out_valid, c_out_last, c_out_ready, c_busy;
  logic [1:0]  c_sel, c_grant;
  logic [3:0]  c_in_valid, c_in_ready;
  logic [31:0] c_in_data;
  logic [7:0]  c_out_data;

  aes_byte_stream_mux #(.WIDTH(8), .NUM_CH(4), .BURST_LEN(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .sel(c_sel), .mode(c_mode),
    .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_last(c_out_last),
    .out_ready(c_out_ready), .grant(c_grant), .busy(c_busy)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 8'h00);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_grant", a_grant, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_in_ready, 2'b00);
  endtask

  // One ch1 burst of bytes 0..15 on DUT A; negative arguments disable the event.
  task automatic burst_a(input int stall_at, input int swap_at, input int rst_at);
    a_sel       = 1'b1;
    a_in_valid  = 2'b11;
    a_in_data   = {8'h00, 8'hAA};
    a_out_ready = 1'b1;
    #1;
    chk("idle_in_ready", a_in_ready, 2'b00);
    chk("idle_busy", a_busy, 0);
    @(negedge clk);
    chk("lock_busy", a_busy, 1);
    chk("lock_grant", a_grant, 1);
    chk("bubble_out_valid", a_out_valid, 0);
    #1;
    chk("lock_in_ready", a_in_ready, 2'b10);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("beat_valid", a_out_valid, 1);
      chk("beat_data", a_out_data, k);
      chk("beat_last", a_out_last, (k == 15) ? 1 : 0);
      if (k == 15) begin
        chk("end_busy", a_busy, 0);
        chk("end_grant", a_grant, 1);
        a_in_valid = 2'b00;
        #1;
        chk("end_in_ready", a_in_ready, 2'b00);
        @(negedge clk);
        chk("drain_valid", a_out_valid, 0);
        return;
      end
      a_in_data[15:8] = 8'(k + 1);
      if (k == swap_at) a_sel = 1'b0;
      if (k == rst_at) begin
        a_rst_n = 1'b0;
        #1;
        chk_reset_a();
        @(negedge clk);
        chk_reset_a();
        a_rst_n = 1'b1;
        return;
      end
      if (k == stall_at) begin
        a_out_ready = 1'b0;
        repeat (3) begin
          #1;
          chk("stall_in_ready", a_in_ready, 2'b00);
          @(negedge clk);
          chk("stall_valid", a_out_valid, 1);
          chk("stall_data", a_out_data, k);
          chk("stall_last", a_out_last, 0);
        end
        a_out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    a_rst_n = 1'b0; rst_n = 1'b0;
    a_sel = 1'b0; a_mode = 1'b0; a_in_valid = '0; a_in_data = '0; a_out_ready = 1'b1;
    b_sel = '0; b_mode = 1'b0; b_in_valid = '0; b_in_data = '0; b_out_ready = 1'b1;
`ifdef AES_BYTE_MUX_RR_EN
    c_sel = '0; c_mode = 1'b1; c_in_valid = '0; c_in_data = '0; c_out_ready = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk_reset_a();
    a_rst_n = 1'b1; rst_n = 1'b1;

    burst_a(-1, 4, -1);   // sel flips to 0 after beat 4
    burst_a(5, -1, -1);   // 3-cycle backpressure on beat 5
    burst_a(-1, -1, 9);   // reset pulse after beat 9
    burst_a(-1, -1, -1);  // next burst must count from beat 0 again

    // Out-of-range sel on a 3-channel mux, then a legal sel
    b_sel      = 2'd3;
    b_in_valid = 3'b111;
    b_in_data  = {8'h5C, 8'h5B, 8'h5A};
    repeat (3) @(negedge clk);
    chk("oor_busy", b_busy, 0);
    chk("oor_grant", b_grant, 0);
    chk("oor_out_valid", b_out_valid, 0);
    chk("oor_in_ready", b_in_ready, 3'b000);
    b_sel = 2'd2;
    @(negedge clk);
    chk("sel2_busy", b_busy, 1);
    chk("sel2_grant", b_grant, 2);
    @(negedge clk);
    chk("sel2_valid", b_out_valid, 1);
    chk("sel2_data", b_out_data, 8'h5C);
    b_in_valid = 3'b000;

`ifdef AES_BYTE_MUX_RR_EN
    begin
      int exp_g [4] = '{0, 1, 3, 0};
      c_in_valid = 4'b1011;
      c_in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        chk("rr_grant", c_grant, exp_g[b]);
        chk("rr_busy", c_busy, 1);
        chk("rr_bubble", c_out_valid, 0);
        @(negedge clk);
        chk("rr_beat0", c_out_data, 8'(exp_g[b] * 8'h11));
        chk("rr_last0", c_out_last, 0);
        @(negedge clk);
        chk("rr_beat1", c_out_data, 8'(exp_g[b] * 8'h11));
        chk("rr_last1", c_out_last, 1);
        chk("rr_idle", c_busy, 0);
      end
      c_in_valid = 4'b0000;
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
